cm_fifo: RTL and testbench



---
 rtl/cm_fifo.sv | 120 ++++++++++++
 tb/tb_cm_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cm_fifo.sv
// cm_fifo
// -------
// Single-clock elastic buffer with a valid/ready write end and a valid/ready
// show-ahead read end. Storage is a circular buffer of DEPTH words; the read
// and write pointers wrap at DEPTH-1, so any depth (including 1 and
// non-power-of-two values) is supported. A separate level counter tells
// full and empty apart, so the pointers need no extra wrap bit.
//
// Parameters:
//   WIDTH  data word width in bits (>= 1)
//   DEPTH  number of storage entries (>= 1)
//   AFULL  almost-full threshold, o_afull = (level >= AFULL), 0..DEPTH
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset (clears pointers and level)
//   i_flush     synchronous clear of all contents
//   i_wr_valid  producer offers i_wr_data
//   o_wr_ready  FIFO can accept a word (not full)
//   i_wr_data   write data, sampled only on an accepted push
//   o_rd_valid  o_rd_data holds the oldest stored word (not empty)
//   i_rd_ready  consumer takes the word this cycle
//   o_rd_data   oldest stored word, combinational from the read pointer
//   o_level     number of stored words, 0..DEPTH
//   o_afull     level >= AFULL
module cm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [LW-1:0]    o_level,
  output logic             o_afull
);

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [LW-1:0]    lvl;
  logic             push;
  logic             pop;

  // Pointer increment with wrap at the last entry rather than at a power of
  // two, so non-power-of-two depths never address a missing entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake flags come only from the registered level, so there is no
  // combinational path from i_wr_valid/i_rd_ready to the ready/valid outputs.
  // A full FIFO refuses writes even when a pop happens in the same cycle.
  always_comb begin
    o_wr_ready = (lvl != LVL_FULL);
    o_rd_valid = (lvl != '0);
    push       = i_wr_valid & o_wr_ready;
    pop        = o_rd_valid & i_rd_ready;
  end

  // A zero threshold is permanently reached; handled separately so the
  // comparison never degenerates into an always-true unsigned compare.
  generate
    if (AFULL == 0) begin : g_afull_const
      assign o_afull = 1'b1;
    end else begin : g_afull_cmp
      assign o_afull = (lvl >= LVL_AFULL);
    end
  endgenerate

  assign o_level   = lvl;
  assign o_rd_data = mem[rp];

  // Pointers and level. Flush wins over any push or pop in the same cycle;
  // a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else if (i_flush) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else begin
      if (push) begin
        wp <= next_ptr(wp);
      end
      if (pop) begin
        rp <= next_ptr(rp);
      end
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // Storage is not reset; a word only becomes visible once the level says
  // it is there, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push && !i_flush) begin
      mem[wp] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_cm_fifo.sv
// Testbench for cm_fifo: three instances (DEPTH=4/AFULL=3, DEPTH=3,
// DEPTH=1) driven with directed vectors. Expected read words are queued
// when a push is issued; a monitor per instance pops and compares whenever
// the instance presents a word that the consumer takes.
module tb_cm_fifo;

  logic clk;
  logic rst_n;

  // Instance A: DEPTH=4, AFULL=3
  logic       a_flush, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready, a_afull;
  logic [7:0] a_wr_data, a_rd_data;
  logic [2:0] a_level;
  // Instance B: DEPTH=3, AFULL=2 (default)
  logic       b_flush, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_afull;
  logic [7:0] b_wr_data, b_rd_data;
  logic [1:0] b_level;
  // Instance C: DEPTH=1, AFULL=0 (default)
  logic       c_flush, c_wr_valid, c_wr_ready, c_rd_valid, c_rd_ready, c_afull;
  logic [7:0] c_wr_data, c_rd_data;
  logic [0:0] c_level;

  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  logic [7:0] sb_c[$];

  int checkCount = 0;
  int passCount  = 0;

  cm_fifo #(.WIDTH(8), .DEPTH(4), .AFULL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_flush(a_flush),
    .i_wr_valid(a_wr_valid), .o_wr_ready(a_wr_ready), .i_wr_data(a_wr_data),
    .o_rd_valid(a_rd_valid), .i_rd_ready(a_rd_ready), .o_rd_data(a_rd_data),
    .o_level(a_level), .o_afull(a_afull)
  );

  cm_fifo #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_flush(b_flush),
    .i_wr_valid(b_wr_valid), .o_wr_ready(b_wr_ready), .i_wr_data(b_wr_data),
    .o_rd_valid(b_rd_valid), .i_rd_ready(b_rd_ready), .o_rd_data(b_rd_data),
    .o_level(b_level), .o_afull(b_afull)
  );

  cm_fifo #(.WIDTH(8), .DEPTH(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_flush(c_flush),
    .i_wr_valid(c_wr_valid), .o_wr_ready(c_wr_ready), .i_wr_data(c_wr_data),
    .o_rd_valid(c_rd_valid), .i_rd_ready(c_rd_ready), .o_rd_data(c_rd_data),
    .o_level(c_level), .o_afull(c_afull)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net against a hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Advance n rising edges; inputs change and checks run 1 unit after the edge
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitors: a word is consumed when valid and ready are both
  // high at the coming edge, so sample on the falling edge before it.
  always @(negedge clk) begin
    if (rst_n && a_rd_valid && a_rd_ready) begin
      if (sb_a.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL a_unexpected_word: got 0x%0h, expected no word", a_rd_data);
      end else begin
        checkOutput("a_rd_data", 32'(a_rd_data), 32'(sb_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_rd_valid && b_rd_ready) begin
      if (sb_b.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL b_unexpected_word: got 0x%0h, expected no word", b_rd_data);
      end else begin
        checkOutput("b_rd_data", 32'(b_rd_data), 32'(sb_b.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_rd_valid && c_rd_ready) begin
      if (sb_c.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL c_unexpected_word: got 0x%0h, expected no word", c_rd_data);
      end else begin
        checkOutput("c_rd_data", 32'(c_rd_data), 32'(sb_c.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {a_flush, a_wr_valid, a_rd_ready, a_wr_data} = '0;
    {b_flush, b_wr_valid, b_rd_ready, b_wr_data} = '0;
    {c_flush, c_wr_valid, c_rd_ready, c_wr_data} = '0;
    applyStimulus(2);
    rst_n = 1'b1;

    // Reset state
    checkOutput("a_reset_wr_ready", 32'(a_wr_ready), 32'd1);
    checkOutput("a_reset_rd_valid", 32'(a_rd_valid), 32'd0);
    checkOutput("a_reset_level",    32'(a_level),    32'd0);
    checkOutput("a_reset_afull",    32'(a_afull),    32'd0);
    checkOutput("b_reset_level",    32'(b_level),    32'd0);
    checkOutput("c_reset_afull",    32'(c_afull),    32'd1);
    applyStimulus(1);
    checkOutput("a_idle_level",     32'(a_level),    32'd0);

    // DEPTH=3: fill with A1..A3, fourth push refused
    b_wr_valid = 1'b1;
    b_wr_data = 8'hA1; sb_b.push_back(8'hA1); applyStimulus(1);
    checkOutput("b_fill_level1", 32'(b_level), 32'd1);
    b_wr_data = 8'hA2; sb_b.push_back(8'hA2); applyStimulus(1);
    checkOutput("b_fill_level2", 32'(b_level), 32'd2);
    checkOutput("b_fill_afull2", 32'(b_afull), 32'd1);
    b_wr_data = 8'hA3; sb_b.push_back(8'hA3); applyStimulus(1);
    checkOutput("b_fill_level3", 32'(b_level), 32'd3);
    checkOutput("b_full_wr_ready", 32'(b_wr_ready), 32'd0);
    b_wr_data = 8'hA4; applyStimulus(1);
    checkOutput("b_ignored_push_level", 32'(b_level), 32'd3);
    b_wr_valid = 1'b0;
    b_rd_ready = 1'b1;
    applyStimulus(1);
    checkOutput("b_drain_level2", 32'(b_level), 32'd2);
    applyStimulus(1);
    checkOutput("b_drain_level1", 32'(b_level), 32'd1);
    applyStimulus(1);
    checkOutput("b_drain_level0", 32'(b_level), 32'd0);
    checkOutput("b_drain_rd_valid", 32'(b_rd_valid), 32'd0);

    // DEPTH=3: stream 0x00..0x09 with push and pop every cycle
    b_wr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b_wr_data = 8'(k);
      sb_b.push_back(8'(k));
      applyStimulus(1);
      checkOutput($sformatf("b_stream_level_%0d", k), 32'(b_level), 32'd1);
    end
    b_wr_valid = 1'b0;
    applyStimulus(1);
    b_rd_ready = 1'b0;
    checkOutput("b_stream_end_level", 32'(b_level), 32'd0);

    // DEPTH=4: fill, then push+pop while full
    a_wr_valid = 1'b1;
    a_wr_data = 8'h11; sb_a.push_back(8'h11); applyStimulus(1);
    checkOutput("a_level1", 32'(a_level), 32'd1);
    a_wr_data = 8'h22; sb_a.push_back(8'h22); applyStimulus(1);
    checkOutput("a_afull_at2", 32'(a_afull), 32'd0);
    a_wr_data = 8'h33; sb_a.push_back(8'h33); applyStimulus(1);
    checkOutput("a_afull_at3", 32'(a_afull), 32'd1);
    a_wr_data = 8'h44; sb_a.push_back(8'h44); applyStimulus(1);
    checkOutput("a_full_level", 32'(a_level), 32'd4);
    checkOutput("a_full_wr_ready", 32'(a_wr_ready), 32'd0);
    a_wr_data = 8'h99;
    a_rd_ready = 1'b1;
    applyStimulus(1);
    checkOutput("a_full_pushpop_level", 32'(a_level), 32'd3);
    checkOutput("a_after_pop_wr_ready", 32'(a_wr_ready), 32'd1);
    a_wr_valid = 1'b0;
    applyStimulus(1);
    a_rd_ready = 1'b0;
    checkOutput("a_pre_flush_level", 32'(a_level), 32'd2);

    // DEPTH=4: flush with a simultaneous push of 0x55
    a_flush = 1'b1;
    a_wr_valid = 1'b1;
    a_wr_data = 8'h55;
    checkOutput("a_flush_cycle_rd_valid", 32'(a_rd_valid), 32'd1);
    applyStimulus(1);
    a_flush = 1'b0;
    a_wr_valid = 1'b0;
    sb_a.delete();
    checkOutput("a_post_flush_level", 32'(a_level), 32'd0);
    checkOutput("a_post_flush_rd_valid", 32'(a_rd_valid), 32'd0);
    applyStimulus(1);
    checkOutput("a_flush_idle_level", 32'(a_level), 32'd0);
    a_wr_valid = 1'b1;
    a_wr_data = 8'h66; sb_a.push_back(8'h66); applyStimulus(1);
    a_wr_valid = 1'b0;
    checkOutput("a_after_flush_level", 32'(a_level), 32'd1);
    a_rd_ready = 1'b1;
    applyStimulus(1);
    a_rd_ready = 1'b0;
    checkOutput("a_final_level", 32'(a_level), 32'd0);

    // DEPTH=1: single entry push/pop, then async reset with a word stored
    c_wr_valid = 1'b1;
    c_wr_data = 8'h7E; sb_c.push_back(8'h7E); applyStimulus(1);
    c_wr_valid = 1'b0;
    checkOutput("c_full_wr_ready", 32'(c_wr_ready), 32'd0);
    checkOutput("c_full_rd_valid", 32'(c_rd_valid), 32'd1);
    checkOutput("c_full_rd_data",  32'(c_rd_data),  32'h7E);
    checkOutput("c_full_level",    32'(c_level),    32'd1);
    c_rd_ready = 1'b1;
    applyStimulus(1);
    c_rd_ready = 1'b0;
    checkOutput("c_empty_rd_valid", 32'(c_rd_valid), 32'd0);
    checkOutput("c_empty_wr_ready", 32'(c_wr_ready), 32'd1);
    c_wr_valid = 1'b1;
    c_wr_data = 8'h3C;
    applyStimulus(1);
    c_wr_valid = 1'b0;
    checkOutput("c_stored_rd_valid", 32'(c_rd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("c_async_rst_rd_valid", 32'(c_rd_valid), 32'd0);
    checkOutput("c_async_rst_wr_ready", 32'(c_wr_ready), 32'd1);
    checkOutput("c_async_rst_level",    32'(c_level),    32'd0);
    checkOutput("c_async_rst_afull",    32'(c_afull),    32'd1);
    applyStimulus(1);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("c_after_rst_level", 32'(c_level), 32'd0);

    // Every queued word must have been seen
    checkOutput("sb_a_empty", 32'(sb_a.size()), 32'd0);
    checkOutput("sb_b_empty", 32'(sb_b.size()), 32'd0);
    checkOutput("sb_c_empty", 32'(sb_c.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
